// File: rtl/dmem_responder.sv
// Data-memory responder: turns M-stage load/store requests into single-outstanding bus transfers.
// Latency: IDLE detect + >=1 REQ cycle (stall held), then one DONE cycle; zero-wait bus gives one access every 3 cycles.
// Backpressure: DStallM freezes the pipeline while a request is pending; BusValid is held with stable fields until BusReady or timeout.
//
// Ports:
//   clk, reset                 core clock, asynchronous active-high reset
//   MemWriteM, MemtoRegM       store / load request from the M stage
//   ByteMaskM, DataAdrM,
//   WriteDataM                 store lanes, byte address, lane-replicated store data
//   ReadDataM                  registered full read word for W-stage extraction
//   DStallM                    stall request to hazard unit
//   DAbortM                    one-cycle data-abort pulse (bus error or timeout)
//   BusValid/BusWrite/BusAdr/
//   BusByteEn/BusWData         request side of the backing bus
//   BusReady/BusRData/BusErr   completion side of the backing bus
module dmem_responder #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic [3:0]  ByteMaskM,
  input  logic [31:0] DataAdrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        DStallM,
  output logic        DAbortM,
  output logic        BusValid,
  output logic        BusWrite,
  output logic [31:0] BusAdr,
  output logic [3:0]  BusByteEn,
  output logic [31:0] BusWData,
  input  logic        BusReady,
  input  logic [31:0] BusRData,
  input  logic        BusErr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [CW-1:0] LastCnt = CW'(TIMEOUT - 1);

  state_t        state, nextState;
  logic [CW-1:0] cnt;
  logic          abortFlag;
  logic          memReq;
  logic          lastCycle;
  logic          unusedAdrBits;

  assign memReq        = MemWriteM | MemtoRegM;
  // cnt counts REQ cycles already spent; this is the TIMEOUT-th REQ cycle.
  assign lastCycle     = (cnt == LastCnt);
  // The bus is word-addressed; the low address bits only matter to W-stage extraction.
  assign unusedAdrBits = ^DataAdrM[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    BusValid  = 1'b0;
    DStallM   = 1'b0;
    DAbortM   = 1'b0;
    case (state)
      IDLE: begin
        // Stall in the detect cycle so the request cannot leave M before it is serviced.
        DStallM = memReq;
        if (memReq) nextState = REQ;
      end
      REQ: begin
        BusValid = 1'b1;
        DStallM  = 1'b1;
        // BusReady on the final cycle is a normal completion, not a timeout.
        if (BusReady || lastCycle) nextState = DONE;
      end
      DONE: begin
        // No stall here: the pipeline advances and the still-visible request is not reissued.
        DAbortM   = abortFlag;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // The pipeline is being reset too; never hold it while reset is asserted.
    if (reset) DStallM = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      abortFlag <= 1'b0;
      ReadDataM <= '0;
      BusWrite  <= 1'b0;
      BusAdr    <= '0;
      BusByteEn <= '0;
      BusWData  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (memReq) begin
            BusAdr    <= {DataAdrM[31:2], 2'b00};
            BusWrite  <= MemWriteM;  // a store wins if both strobes are high
            BusByteEn <= MemWriteM ? ByteMaskM : 4'b1111;
            BusWData  <= WriteDataM;
          end
        end
        REQ: begin
          // Exits by TIMEOUT at the latest and TIMEOUT < 2^CW, so this never wraps.
          cnt <= cnt + CW'(1);
          if (BusReady) begin
            if (BusErr) begin
              abortFlag <= 1'b1;
              ReadDataM <= '0;
            end else if (!BusWrite) begin
              ReadDataM <= BusRData;
            end
          end else if (lastCycle) begin
            abortFlag <= 1'b1;
            ReadDataM <= '0;
          end
        end
        DONE: abortFlag <= 1'b0;
        default: abortFlag <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with TIMEOUT=4.
// Inputs are driven 1ns after the rising edge; outputs are checked on the falling edge.
// Covers reset values, load, byte store, bus error, back-to-back loads, timeout and reset mid-REQ.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWriteM, MemtoRegM;
  logic [3:0]  ByteMaskM;
  logic [31:0] DataAdrM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        DStallM, DAbortM;
  logic        BusValid, BusWrite;
  logic [31:0] BusAdr;
  logic [3:0]  BusByteEn;
  logic [31:0] BusWData;
  logic        BusReady, BusErr;
  logic [31:0] BusRData;

  int passed = 0;
  int total  = 0;
  int handshakes = 0;
  int hsBase;

  dmem_responder #(.TIMEOUT(4), .CW(8)) dut (
    .clk(clk), .reset(reset),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .ByteMaskM(ByteMaskM),
    .DataAdrM(DataAdrM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .DStallM(DStallM), .DAbortM(DAbortM),
    .BusValid(BusValid), .BusWrite(BusWrite), .BusAdr(BusAdr),
    .BusByteEn(BusByteEn), .BusWData(BusWData),
    .BusReady(BusReady), .BusRData(BusRData), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  // Count accepted bus transfers, sampled away from the rising edge.
  always @(negedge clk) if (BusValid && BusReady) handshakes++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; MemWriteM = 0; MemtoRegM = 0; ByteMaskM = 0;
    DataAdrM = 0; WriteDataM = 0; BusReady = 0; BusErr = 0; BusRData = 0;
    #3;
    check("rst ReadDataM", ReadDataM, 32'h0);
    check("rst DStallM",   32'(DStallM), 32'h0);
    check("rst DAbortM",   32'(DAbortM), 32'h0);
    check("rst BusValid",  32'(BusValid), 32'h0);
    check("rst BusWrite",  32'(BusWrite), 32'h0);
    check("rst BusAdr",    BusAdr, 32'h0);
    check("rst BusByteEn", 32'(BusByteEn), 32'h0);
    check("rst BusWData",  BusWData, 32'h0);
    tick(); tick();
    reset = 1'b0;

    // Load from 0x1003, BusReady in the 2nd REQ cycle.
    tick(); MemtoRegM = 1; DataAdrM = 32'h1003;
    sample(); check("ld idle stall", 32'(DStallM), 32'h1);
    check("ld idle valid", 32'(BusValid), 32'h0);
    tick(); sample();
    check("ld req1 valid", 32'(BusValid), 32'h1);
    check("ld req1 stall", 32'(DStallM), 32'h1);
    check("ld BusAdr", BusAdr, 32'h1000);
    check("ld BusByteEn", 32'(BusByteEn), 32'hF);
    check("ld BusWrite", 32'(BusWrite), 32'h0);
    tick(); BusReady = 1; BusRData = 32'hDEADBEEF;
    sample(); check("ld req2 stall", 32'(DStallM), 32'h1);
    tick(); BusReady = 0;
    sample(); check("ld done stall", 32'(DStallM), 32'h0);
    check("ld done valid", 32'(BusValid), 32'h0);
    check("ld ReadDataM", ReadDataM, 32'hDEADBEEF);
    check("ld done abort", 32'(DAbortM), 32'h0);
    tick(); MemtoRegM = 0;
    sample(); check("ld idle after", 32'(DStallM), 32'h0);

    // Byte store, zero-wait bus.
    tick(); MemWriteM = 1; ByteMaskM = 4'b0100; WriteDataM = 32'h5A5A5A5A;
    DataAdrM = 32'h2002; BusReady = 1; BusRData = 32'h11111111;
    tick(); sample();
    check("st BusWrite", 32'(BusWrite), 32'h1);
    check("st BusByteEn", 32'(BusByteEn), 32'h4);
    check("st BusAdr", BusAdr, 32'h2000);
    check("st BusWData", BusWData, 32'h5A5A5A5A);
    check("st req valid", 32'(BusValid), 32'h1);
    tick(); BusReady = 0;
    sample(); check("st ReadDataM kept", ReadDataM, 32'hDEADBEEF);
    check("st abort", 32'(DAbortM), 32'h0);
    check("st done stall", 32'(DStallM), 32'h0);
    tick(); MemWriteM = 0;

    // Both strobes high: the write wins and uses the store mask.
    tick(); MemWriteM = 1; MemtoRegM = 1; ByteMaskM = 4'b0011; DataAdrM = 32'h2100;
    tick(); sample();
    check("both BusWrite", 32'(BusWrite), 32'h1);
    check("both BusByteEn", 32'(BusByteEn), 32'h3);
    tick(); BusReady = 1;
    tick(); BusReady = 0;
    tick(); MemWriteM = 0; MemtoRegM = 0;

    // Bus error on a load.
    tick(); MemtoRegM = 1; DataAdrM = 32'h3000;
    tick(); BusReady = 1; BusErr = 1; BusRData = 32'h12345678;
    tick(); BusReady = 0; BusErr = 0;
    sample(); check("err DAbortM", 32'(DAbortM), 32'h1);
    check("err ReadDataM", ReadDataM, 32'h0);
    tick(); MemtoRegM = 0;
    sample(); check("err abort pulse end", 32'(DAbortM), 32'h0);

    // Back-to-back zero-wait loads; the request stays up through DONE.
    hsBase = handshakes;
    tick(); MemtoRegM = 1; DataAdrM = 32'h5004; BusReady = 1; BusRData = 32'hA5A50001;
    tick(); sample();
    check("b2b1 BusAdr", BusAdr, 32'h5004);
    check("b2b1 valid", 32'(BusValid), 32'h1);
    tick(); sample();
    check("b2b1 ReadDataM", ReadDataM, 32'hA5A50001);
    check("b2b1 done valid", 32'(BusValid), 32'h0);
    check("b2b1 done stall", 32'(DStallM), 32'h0);
    tick(); DataAdrM = 32'h5008; BusRData = 32'hA5A50002;
    sample(); check("b2b2 idle stall", 32'(DStallM), 32'h1);
    check("b2b2 idle valid", 32'(BusValid), 32'h0);
    tick(); sample();
    check("b2b2 BusAdr", BusAdr, 32'h5008);
    check("b2b2 valid", 32'(BusValid), 32'h1);
    tick(); sample();
    check("b2b2 ReadDataM", ReadDataM, 32'hA5A50002);
    tick(); MemtoRegM = 0; BusReady = 0;
    sample(); check("b2b handshakes", 32'(handshakes - hsBase), 32'd2);

    // Timeout: BusReady never arrives.
    tick(); MemtoRegM = 1; DataAdrM = 32'h4000;
    for (int i = 1; i <= 4; i++) begin
      tick(); sample();
      check($sformatf("to req%0d valid", i), 32'(BusValid), 32'h1);
    end
    tick(); sample();
    check("to done valid", 32'(BusValid), 32'h0);
    check("to DAbortM", 32'(DAbortM), 32'h1);
    check("to ReadDataM", ReadDataM, 32'h0);
    check("to done stall", 32'(DStallM), 32'h0);
    tick(); MemtoRegM = 0;
    sample(); check("to idle abort", 32'(DAbortM), 32'h0);
    check("to idle valid", 32'(BusValid), 32'h0);

    // Reset during the 2nd REQ cycle.
    tick(); MemtoRegM = 1; DataAdrM = 32'h6000;
    tick(); tick();
    sample(); check("rr req2 valid", 32'(BusValid), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("rr valid", 32'(BusValid), 32'h0);
    check("rr stall", 32'(DStallM), 32'h0);
    check("rr abort", 32'(DAbortM), 32'h0);
    check("rr BusAdr", BusAdr, 32'h0);
    tick(); MemtoRegM = 0; reset = 1'b0;
    sample(); check("rr idle valid", 32'(BusValid), 32'h0);
    check("rr idle abort", 32'(DAbortM), 32'h0);
    tick(); sample();
    check("rr later abort", 32'(DAbortM), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
